// File: rtl/test_seq_pkg.sv
// Shared types and limits for the test sequencer.
package test_seq_pkg;

  localparam int unsigned NUM_CH_MAX = 16;
  localparam int unsigned IDX_W      = 5;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    NEXT,
    REPORT
  } state_e;

  typedef enum logic {
    SEQ,
    PAR
  } mode_e;

  // Index of the lowest set bit; 0 when the mask is empty.
  function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_CH_MAX-1:0] m);
    lowest_idx = '0;
    for (int i = NUM_CH_MAX - 1; i >= 0; i--) begin
      if (m[i]) lowest_idx = IDX_W'(i);
    end
  endfunction

endpackage

// File: rtl/test_seq_timer.sv
// Saturating per-run timeout counter; expired is registered alongside the count.
module test_seq_timer #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         expired
);

  logic [W-1:0] count;
  logic [W-1:0] count_inc;

  assign count_inc = (count == '1) ? count : count + W'(1);

  // Limit 0 disables the timeout, so expired never rises.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count   <= '0;
      expired <= 1'b0;
    end else if (clear) begin
      count   <= '0;
      expired <= 1'b0;
    end else if (enable) begin
      count   <= count_inc;
      expired <= (limit != '0) && (count_inc == limit);
    end
  end

endmodule

// File: rtl/test_sequencer.sv
// Launches enabled test channels (one by one or all at once), collects verdicts and timeouts.
module test_sequencer
  import test_seq_pkg::*;
#(
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned TMO_W  = 16,
  parameter mode_e       MODE   = SEQ
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [NUM_CH-1:0]           ch_en,
  input  logic [TMO_W-1:0]            tmo_cycles,
  output logic [NUM_CH-1:0]           ch_start,
  input  logic [NUM_CH-1:0]           ch_done,
  input  logic [NUM_CH-1:0]           ch_pass,
  output logic                        busy,
  output logic                        done,
  output logic [NUM_CH-1:0]           pass_mask,
  output logic [NUM_CH-1:0]           tmo_mask,
  output logic                        all_pass,
  output logic [$clog2(NUM_CH):0]     active_ch
);

  localparam int unsigned AW = $clog2(NUM_CH) + 1;

  state_e            state_q, state_d;
  logic [NUM_CH-1:0] en_q, en_d;
  logic [TMO_W-1:0]  lim_q, lim_d;
  logic [NUM_CH-1:0] run_q, run_d;
  logic [NUM_CH-1:0] res_q, res_d;
  logic [NUM_CH-1:0] pass_d, tmo_d, start_d;
  logic [AW-1:0]     act_d;
  logic              all_pass_d;
  logic [NUM_CH-1:0] cur_oh, remain, new_done, res_nxt, launch_m;
  logic              do_launch;
  logic              tmr_clear, tmr_en, expired;

  test_seq_timer #(.W(TMO_W)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (tmr_clear),
    .enable  (tmr_en),
    .limit   (lim_q),
    .expired (expired)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    en_d      = en_q;
    lim_d     = lim_q;
    run_d     = run_q;
    res_d     = res_q;
    pass_d    = pass_mask;
    tmo_d     = tmo_mask;
    start_d   = '0;
    act_d     = active_ch;
    tmr_clear = 1'b0;
    tmr_en    = 1'b0;
    do_launch = 1'b0;
    launch_m  = '0;
    res_nxt   = res_q;
    cur_oh    = NUM_CH'(1) << active_ch;
    remain    = en_q & ~run_q;
    new_done  = ch_done & en_q & ~res_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          en_d   = ch_en;
          lim_d  = tmo_cycles;
          pass_d = '0;
          tmo_d  = '0;
          run_d  = '0;
          res_d  = '0;
          act_d  = '0;
          if (ch_en == '0) begin
            state_d = NEXT;
          end else begin
            state_d   = LAUNCH;
            do_launch = 1'b1;
            launch_m  = ch_en;
          end
        end
      end
      LAUNCH: begin
        tmr_clear = 1'b1;
        state_d   = WAIT;
      end
      WAIT: begin
        tmr_en = 1'b1;
        if (MODE == PAR) begin
          res_nxt = res_q | new_done;
          res_d   = res_nxt;
          pass_d  = pass_mask | (new_done & ch_pass);
          if (res_nxt == en_q) begin
            state_d = NEXT;
          end else if (expired) begin
            tmo_d   = en_q & ~res_nxt;
            state_d = NEXT;
          end
        end else begin
          // A completion strobe in the timeout cycle still counts as a verdict.
          if ((ch_done & cur_oh & en_q) != '0) begin
            pass_d  = (pass_mask & ~cur_oh) | (ch_pass & cur_oh);
            state_d = NEXT;
            act_d   = '0;
          end else if (expired) begin
            tmo_d   = tmo_mask | cur_oh;
            pass_d  = pass_mask & ~cur_oh;
            state_d = NEXT;
            act_d   = '0;
          end
        end
      end
      NEXT: begin
        if (MODE == SEQ && remain != '0) begin
          state_d   = LAUNCH;
          do_launch = 1'b1;
          launch_m  = remain;
        end else begin
          state_d = REPORT;
        end
      end
      REPORT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (do_launch) begin
      if (MODE == PAR) begin
        start_d = launch_m;
      end else begin
        start_d = launch_m & (~launch_m + NUM_CH'(1));
        act_d   = AW'(lowest_idx(NUM_CH_MAX'(launch_m)));
      end
      run_d = run_d | start_d;
    end

    all_pass_d = (pass_d == en_d) && (en_d != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      en_q      <= '0;
      lim_q     <= '0;
      run_q     <= '0;
      res_q     <= '0;
      ch_start  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass_mask <= '0;
      tmo_mask  <= '0;
      all_pass  <= 1'b0;
      active_ch <= '0;
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      lim_q     <= lim_d;
      run_q     <= run_d;
      res_q     <= res_d;
      ch_start  <= start_d;
      busy      <= (state_d != IDLE);
      done      <= (state_d == REPORT);
      pass_mask <= pass_d;
      tmo_mask  <= tmo_d;
      all_pass  <= all_pass_d;
      active_ch <= act_d;
    end
  end

endmodule

// File: tb/tb_test_sequencer.sv
// Directed bench: per-cycle vector table on a SEQ instance plus multi-cycle runs on SEQ and PAR instances.
module tb_test_sequencer;
  import test_seq_pkg::*;

  localparam int unsigned N  = 3;
  localparam int unsigned TW = 16;
  localparam int unsigned AW = $clog2(N) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_s, start_p;
  logic [N-1:0]  ch_en;
  logic [TW-1:0] tmo;
  logic [N-1:0]  tbl_dn, tbl_ps;
  logic [N-1:0]  rsp_dn = '0;
  logic [N-1:0]  rsp_ps = '0;
  logic [N-1:0]  ch_done, ch_pass;

  logic [N-1:0]  ch_start_s, pass_s, tmo_s;
  logic          busy_s, done_s, all_s;
  logic [AW-1:0] act_s;
  logic [N-1:0]  ch_start_p, pass_p, tmo_p;
  logic          busy_p, done_p, all_p;
  logic [AW-1:0] act_p;

  assign ch_done = tbl_dn | rsp_dn;
  assign ch_pass = tbl_ps | rsp_ps;

  always #5 clk = ~clk;

  test_sequencer #(.NUM_CH(N), .TMO_W(TW), .MODE(SEQ)) u_seq (
    .clk(clk), .rst_n(rst_n), .start(start_s), .ch_en(ch_en), .tmo_cycles(tmo),
    .ch_start(ch_start_s), .ch_done(ch_done), .ch_pass(ch_pass), .busy(busy_s),
    .done(done_s), .pass_mask(pass_s), .tmo_mask(tmo_s), .all_pass(all_s),
    .active_ch(act_s)
  );

  test_sequencer #(.NUM_CH(N), .TMO_W(TW), .MODE(PAR)) u_par (
    .clk(clk), .rst_n(rst_n), .start(start_p), .ch_en(ch_en), .tmo_cycles(tmo),
    .ch_start(ch_start_p), .ch_done(ch_done), .ch_pass(ch_pass), .busy(busy_p),
    .done(done_p), .pass_mask(pass_p), .tmo_mask(tmo_p), .all_pass(all_p),
    .active_ch(act_p)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Channel model: answers each ch_start after rsp_dly[i] cycles (0 = never answers).
  int           rsp_dly[N];
  int           rsp_cnt[N];
  logic [N-1:0] rsp_pv;
  bit           rsp_par;

  always @(posedge clk) begin
    logic [N-1:0] launch;
    #1;
    launch = rsp_par ? ch_start_p : ch_start_s;
    rsp_dn = '0;
    rsp_ps = '0;
    for (int i = 0; i < N; i++) begin
      if (rsp_cnt[i] > 0) begin
        rsp_cnt[i]--;
        if (rsp_cnt[i] == 0) begin
          rsp_dn[i] = 1'b1;
          rsp_ps[i] = rsp_pv[i];
        end
      end
      if (launch[i] && rsp_dly[i] > 0) rsp_cnt[i] = rsp_dly[i];
    end
  end

  typedef struct {
    logic          rst_n;
    logic          start;
    logic [N-1:0]  en;
    logic [TW-1:0] tmo;
    logic [N-1:0]  dn;
    logic [N-1:0]  ps;
    logic [N-1:0]  e_start;
    logic          e_busy;
    logic          e_done;
    logic [N-1:0]  e_pass;
    logic [N-1:0]  e_tmo;
    logic          e_all;
    logic [AW-1:0] e_act;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic s, input logic [N-1:0] en, input logic [TW-1:0] t,
                     input logic [N-1:0] dn, input logic [N-1:0] ps,
                     input logic [N-1:0] es, input logic eb, input logic ed,
                     input logic [N-1:0] ep, input logic [N-1:0] et, input logic ea,
                     input logic [AW-1:0] eact);
    vec_t v;
    v.rst_n = r; v.start = s; v.en = en; v.tmo = t; v.dn = dn; v.ps = ps;
    v.e_start = es; v.e_busy = eb; v.e_done = ed; v.e_pass = ep; v.e_tmo = et;
    v.e_all = ea; v.e_act = eact;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pk_s();
    return 32'({ch_start_s, busy_s, done_s, pass_s, tmo_s, all_s, act_s});
  endfunction

  function automatic logic [31:0] pk_p();
    return 32'({ch_start_p, busy_p, done_p, pass_p, tmo_p, all_p, act_p});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rsp(input bit par, input int d0, input int d1, input int d2,
                         input logic [N-1:0] pv);
    rsp_par    = par;
    rsp_dly[0] = d0;
    rsp_dly[1] = d1;
    rsp_dly[2] = d2;
    rsp_pv     = pv;
  endtask

  task automatic go(input bit par, input logic [N-1:0] en, input logic [TW-1:0] t);
    ch_en = en;
    tmo   = t;
    if (par) start_p = 1'b1;
    else     start_s = 1'b1;
    tick();
    start_s = 1'b0;
    start_p = 1'b0;
  endtask

  logic [N-1:0] w_starts[$];
  int           w_done_n, w_done_cyc, w_last_dn;

  // Observe one run from the launch cycle until two cycles past done, bounded by budget.
  task automatic watch(input bit par, input int budget);
    bit seen;
    int extra;
    w_starts.delete();
    w_done_n = 0; w_done_cyc = -1; w_last_dn = -1;
    seen = 1'b0; extra = 0;
    for (int cyc = 0; cyc < budget && extra < 3; cyc++) begin
      @(negedge clk);
      if ((par ? ch_start_p : ch_start_s) != '0) w_starts.push_back(par ? ch_start_p : ch_start_s);
      if (rsp_dn != '0) w_last_dn = cyc;
      if (par ? done_p : done_s) begin
        w_done_n++;
        w_done_cyc = cyc;
        seen = 1'b1;
      end
      if (seen) extra++;
    end
    chk("run_completes", 32'(seen), 32'd1);
  endtask

  task automatic run_all_pass(input string tag);
    set_rsp(1'b0, 10, 10, 10, 3'b111);
    go(1'b0, 3'b111, 16'd100);
    watch(1'b0, 200);
    chk({tag, "_n_start"}, 32'(w_starts.size()), 32'd3);
    chk({tag, "_start0"}, 32'(w_starts[0]), 32'(3'b001));
    chk({tag, "_start1"}, 32'(w_starts[1]), 32'(3'b010));
    chk({tag, "_start2"}, 32'(w_starts[2]), 32'(3'b100));
    chk({tag, "_pass"}, 32'(pass_s), 32'(3'b111));
    chk({tag, "_tmo"}, 32'(tmo_s), 32'd0);
    chk({tag, "_all_pass"}, 32'(all_s), 32'd1);
    chk({tag, "_n_done"}, 32'(w_done_n), 32'd1);
    chk({tag, "_idle"}, 32'(busy_s), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start_s = 1'b0; start_p = 1'b0; ch_en = '0; tmo = '0;
    tbl_dn = '0; tbl_ps = '0;
    set_rsp(1'b0, 0, 0, 0, 3'b000);

    //  rst st en     tmo  dn     ps      start  bsy dn pass   tmo    all act
    add(0, 0, 3'b000, 0,   3'b000, 3'b000, 3'b000, 0, 0, 3'b000, 3'b000, 0, 0);
    add(1, 1, 3'b011, 3,   3'b000, 3'b000, 3'b001, 1, 0, 3'b000, 3'b000, 0, 0);
    add(1, 0, 3'b011, 3,   3'b001, 3'b001, 3'b000, 1, 0, 3'b000, 3'b000, 0, 0);
    add(1, 0, 3'b011, 3,   3'b000, 3'b000, 3'b000, 1, 0, 3'b000, 3'b000, 0, 0);
    add(1, 0, 3'b011, 3,   3'b001, 3'b001, 3'b000, 1, 0, 3'b001, 3'b000, 0, 0);
    add(1, 0, 3'b011, 3,   3'b000, 3'b000, 3'b010, 1, 0, 3'b001, 3'b000, 0, 1);
    add(1, 0, 3'b011, 3,   3'b010, 3'b010, 3'b000, 1, 0, 3'b001, 3'b000, 0, 1);
    add(1, 0, 3'b011, 3,   3'b001, 3'b001, 3'b000, 1, 0, 3'b001, 3'b000, 0, 1);
    add(1, 0, 3'b011, 3,   3'b000, 3'b000, 3'b000, 1, 0, 3'b001, 3'b000, 0, 1);
    add(1, 0, 3'b011, 3,   3'b000, 3'b000, 3'b000, 1, 0, 3'b001, 3'b000, 0, 1);
    add(1, 0, 3'b011, 3,   3'b000, 3'b000, 3'b000, 1, 0, 3'b001, 3'b010, 0, 0);
    add(1, 1, 3'b011, 3,   3'b000, 3'b000, 3'b000, 1, 1, 3'b001, 3'b010, 0, 0);
    add(1, 1, 3'b011, 3,   3'b000, 3'b000, 3'b000, 0, 0, 3'b001, 3'b010, 0, 0);
    add(1, 0, 3'b011, 3,   3'b000, 3'b000, 3'b000, 0, 0, 3'b001, 3'b010, 0, 0);
    add(1, 1, 3'b000, 3,   3'b000, 3'b000, 3'b000, 1, 0, 3'b000, 3'b000, 0, 0);
    add(1, 0, 3'b000, 3,   3'b000, 3'b000, 3'b000, 1, 1, 3'b000, 3'b000, 0, 0);
    add(1, 0, 3'b000, 3,   3'b000, 3'b000, 3'b000, 0, 0, 3'b000, 3'b000, 0, 0);
    add(1, 1, 3'b001, 0,   3'b000, 3'b000, 3'b001, 1, 0, 3'b000, 3'b000, 0, 0);
    add(1, 0, 3'b001, 0,   3'b000, 3'b000, 3'b000, 1, 0, 3'b000, 3'b000, 0, 0);
    add(1, 0, 3'b001, 0,   3'b000, 3'b000, 3'b000, 1, 0, 3'b000, 3'b000, 0, 0);
    add(1, 0, 3'b001, 0,   3'b000, 3'b000, 3'b000, 1, 0, 3'b000, 3'b000, 0, 0);
    add(1, 0, 3'b001, 0,   3'b001, 3'b001, 3'b000, 1, 0, 3'b001, 3'b000, 1, 0);
    add(1, 0, 3'b001, 0,   3'b000, 3'b000, 3'b000, 1, 1, 3'b001, 3'b000, 1, 0);
    add(1, 0, 3'b001, 0,   3'b000, 3'b000, 3'b000, 0, 0, 3'b001, 3'b000, 1, 0);

    tick();
    tick();

    foreach (vq[i]) begin
      rst_n   = vq[i].rst_n;
      start_s = vq[i].start;
      ch_en   = vq[i].en;
      tmo     = vq[i].tmo;
      tbl_dn  = vq[i].dn;
      tbl_ps  = vq[i].ps;
      tick();
      chk($sformatf("vec%0d", i), pk_s(),
          32'({vq[i].e_start, vq[i].e_busy, vq[i].e_done, vq[i].e_pass,
               vq[i].e_tmo, vq[i].e_all, vq[i].e_act}));
    end
    start_s = 1'b0; tbl_dn = '0; tbl_ps = '0; rst_n = 1'b1;
    tick();

    run_all_pass("seq_all");

    // Channel 2 never answers; channel 1 is not enabled.
    set_rsp(1'b0, 3, 0, 0, 3'b001);
    go(1'b0, 3'b101, 16'd20);
    watch(1'b0, 200);
    chk("seq_tmo_n_start", 32'(w_starts.size()), 32'd2);
    chk("seq_tmo_start0", 32'(w_starts[0]), 32'(3'b001));
    chk("seq_tmo_start1", 32'(w_starts[1]), 32'(3'b100));
    chk("seq_tmo_mask", 32'(tmo_s), 32'(3'b100));
    chk("seq_tmo_pass", 32'(pass_s), 32'(3'b001));
    chk("seq_tmo_all_pass", 32'(all_s), 32'd0);

    // Done strobe in the cycle the counter reads 20 beats the timeout.
    set_rsp(1'b0, 21, 0, 0, 3'b001);
    go(1'b0, 3'b001, 16'd20);
    watch(1'b0, 200);
    chk("tie_pass", 32'(pass_s), 32'(3'b001));
    chk("tie_tmo", 32'(tmo_s), 32'd0);
    chk("tie_all_pass", 32'(all_s), 32'd1);

    // One cycle later is too late.
    set_rsp(1'b0, 22, 0, 0, 3'b001);
    go(1'b0, 3'b001, 16'd20);
    watch(1'b0, 200);
    chk("late_pass", 32'(pass_s), 32'd0);
    chk("late_tmo", 32'(tmo_s), 32'(3'b001));
    chk("late_all_pass", 32'(all_s), 32'd0);

    set_rsp(1'b1, 5, 7, 9, 3'b101);
    go(1'b1, 3'b111, 16'd100);
    watch(1'b1, 200);
    chk("par_n_start", 32'(w_starts.size()), 32'd1);
    chk("par_start", 32'(w_starts[0]), 32'(3'b111));
    chk("par_pass", 32'(pass_p), 32'(3'b101));
    chk("par_tmo", 32'(tmo_p), 32'd0);
    chk("par_all_pass", 32'(all_p), 32'd0);
    chk("par_n_done", 32'(w_done_n), 32'd1);
    chk("par_done_latency_ok",
        32'((w_done_cyc - w_last_dn >= 1) && (w_done_cyc - w_last_dn <= 2)), 32'd1);

    set_rsp(1'b1, 3, 0, 0, 3'b001);
    go(1'b1, 3'b011, 16'd10);
    watch(1'b1, 200);
    chk("par_tmo_pass", 32'(pass_p), 32'(3'b001));
    chk("par_tmo_mask", 32'(tmo_p), 32'(3'b010));
    chk("par_tmo_all_pass", 32'(all_p), 32'd0);

    // Abort a SEQ run during WAIT.
    set_rsp(1'b0, 0, 0, 0, 3'b000);
    go(1'b0, 3'b111, 16'd100);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("abort_running%0d", k), 32'({busy_s, done_s}), 32'(2'b10));
    end
    rst_n = 1'b0;
    tick();
    chk("abort_reset_seq", pk_s(), 32'd0);
    chk("abort_reset_par", pk_p(), 32'd0);
    rst_n  = 1'b1;
    tbl_dn = 3'b111;
    tbl_ps = 3'b111;
    tick();
    tbl_dn = '0;
    tbl_ps = '0;
    chk("post_reset_idle", pk_s(), 32'd0);
    tick();
    chk("post_reset_idle2", pk_s(), 32'd0);

    run_all_pass("rerun");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
